// File: rtl/fb_write_arbiter.sv
// Write-side arbiter for the 128x128 pixel memory: queues pixel writes and sequences screen fills,
// issuing memory writes only while the display scan is outside the visible window.
module fb_write_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            read_mem,
  input  logic                            read_mem_vertical,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
  input  logic                            fill_start,
  input  logic [DATA_W-1:0]               fill_color,
  output logic                            fill_busy,
  output logic                            mem_we,
  output logic [ADDR_W-1:0]               mem_waddr,
  output logic [DATA_W-1:0]               mem_wdata,
  output logic [$clog2(FIFO_DEPTH):0]     pending,
  output logic                            overflow_err
);
  localparam int IW = $clog2(FIFO_DEPTH);
  localparam int PW = IW + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, FILL} state_t;
  state_t state;

  logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [FIFO_DEPTH];
  logic [IW-1:0]     rd_ptr, wr_ptr;
  logic [PW-1:0]     count, count_nxt;
  logic [ADDR_W-1:0] fill_cnt, hold_addr;
  logic [DATA_W-1:0] fill_col, hold_data;
  logic              fill_pend, open, push, pop, fill_take;

  assign open      = ~(read_mem & read_mem_vertical);
  assign wr_ready  = (count != PW'(FIFO_DEPTH));
  assign push      = wr_valid & wr_ready;
  assign pop       = mem_we & (state == DRAIN);
  assign count_nxt = count + PW'(push) - PW'(pop);
  assign pending   = count;
  assign fill_busy = fill_pend | (state == FILL);
  assign fill_take = fill_start & ~fill_busy;

  // Address/data fall back to the last driven values whenever no write is issued.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = hold_addr;
    mem_wdata = hold_data;
    case (state)
      DRAIN: if (open && count != '0) begin
        mem_we    = 1'b1;
        mem_waddr = q_addr[rd_ptr];
        mem_wdata = q_data[rd_ptr];
      end
      FILL: if (open) begin
        mem_we    = 1'b1;
        mem_waddr = fill_cnt;
        mem_wdata = fill_col;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= wr_addr;
      q_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      fill_cnt     <= '0;
      fill_col     <= '0;
      fill_pend    <= 1'b0;
      hold_addr    <= '0;
      hold_data    <= '0;
      overflow_err <= 1'b0;
    end else begin
      count <= count_nxt;
      if (push) wr_ptr <= wr_ptr + IW'(1);
      if (pop)  rd_ptr <= rd_ptr + IW'(1);
      if (wr_valid && !wr_ready) overflow_err <= 1'b1;
      if (mem_we) begin
        hold_addr <= mem_waddr;
        hold_data <= mem_wdata;
      end
      case (state)
        IDLE: begin
          if (fill_start) begin
            fill_col <= fill_color;
            fill_cnt <= '0;
            state    <= FILL;
          end else if (count_nxt != '0) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fill_take) fill_col <= fill_color;
          // A fill requested behind queued writes starts only once the queue is empty.
          if (count_nxt == '0) begin
            if (fill_pend || fill_take) begin
              state     <= FILL;
              fill_cnt  <= '0;
              fill_pend <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else if (fill_take) begin
            fill_pend <= 1'b1;
          end
        end
        FILL: begin
          if (mem_we) begin
            fill_cnt <= fill_cnt + ADDR_W'(1);
            if (fill_cnt == '1) state <= (count_nxt != '0) ? DRAIN : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
